// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and sizing helpers for the ALU request arbiter.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (index 0 wins).
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam int NB_DATA_DEF = 4;
    localparam int NB_OP_DEF   = 6;
    localparam int N_REQ_DEF   = 2;
    localparam int ALU_LAT_DEF = 1;

    localparam int CNT_W = $clog2(ALU_LAT_DEF + 1);
    localparam int IDX_W = $clog2(N_REQ_DEF);

    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

    // Keeps index vectors at least one bit wide.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester-side bundle: request and response valid/ready channels.
// master = requesters, slave = arbiter.
interface alu_req_arbiter_if #(
    parameter int N_REQ   = 2,
    parameter int NB_DATA = 4,
    parameter int NB_OP   = 6
);

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*NB_DATA-1:0] req_datoA;
    logic [N_REQ*NB_DATA-1:0] req_datoB;
    logic [N_REQ*NB_OP-1:0]   req_op;
    logic [N_REQ-1:0]         rsp_valid;
    logic [N_REQ-1:0]         rsp_ready;
    logic [NB_DATA-1:0]       rsp_data;

    modport master (
        output req_valid,
        output req_datoA,
        output req_datoB,
        output req_op,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_datoA,
        input  req_datoB,
        input  req_op,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/alu_req_arbiter_rr_grant.sv
// Combinational rotating priority pick: first valid at or above
// i_ptr, wrapping modulo N_REQ; one-hot grant plus its index.
module rr_grant
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    logic [IW-1:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_k = IW'((int'(i_ptr) + i) % N_REQ);
            if (!o_any && i_valid[w_k]) begin
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between N_REQ requesters, one transaction at a time.
// Build option: ALU_ARB_FIXED_PRIO_EN makes index 0 always highest priority.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NB_DATA = 4,
    parameter int NB_OP   = 6,
    parameter int N_REQ   = 2,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               i_rst_n,
    alu_req_arbiter_if.slave   bus,
    output logic [NB_DATA-1:0] o_alu_datoA,
    output logic [NB_DATA-1:0] o_alu_datoB,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy
);

    localparam int CW = cnt_width(ALU_LAT);
    localparam int IW = idx_width(N_REQ);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_idx;
    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic [NB_DATA-1:0] r_rsp_data;
    logic [N_REQ-1:0]   r_rsp_valid;

    logic [N_REQ-1:0]   w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic [IW-1:0]      w_ptr;
    logic               w_accept;
    logic               w_done;
    logic               w_rsp_ack;
    logic [N_REQ-1:0]   w_win_oh;

    assign w_accept  = (r_state == ST_IDLE) && w_any;
    assign w_done    = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_rsp_ack = (r_state == ST_RESP) && bus.rsp_ready[r_idx];

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IW-1:0] r_ptr;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_rsp_ack) begin
            r_ptr <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + IW'(1);
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_grant #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_grant (
        .i_valid (bus.req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_any)     w_next = ST_WAIT;
            ST_WAIT: if (w_done)    w_next = ST_RESP;
            ST_RESP: if (w_rsp_ack) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Ready is masked during reset so nothing looks accepted while held.
    always_comb begin
        bus.req_ready = '0;
        o_busy        = 1'b1;
        if (r_state == ST_IDLE) begin
            o_busy = 1'b0;
            if (i_rst_n) begin
                bus.req_ready = w_grant;
            end
        end
    end

    always_comb begin
        w_win_oh        = '0;
        w_win_oh[r_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_accept) begin
            r_cnt    <= CW'(ALU_LAT);
            r_idx    <= w_idx;
            r_alu_a  <= bus.req_datoA[w_idx*NB_DATA +: NB_DATA];
            r_alu_b  <= bus.req_datoB[w_idx*NB_DATA +: NB_DATA];
            r_alu_op <= bus.req_op[w_idx*NB_OP +: NB_OP];
        end else if ((r_state == ST_WAIT) && !w_done) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= '0;
        end else if (w_done) begin
            r_rsp_data  <= i_alu_result;
            r_rsp_valid <= w_win_oh;
        end else if (w_rsp_ack) begin
            r_rsp_valid <= '0;
        end
    end

    assign o_alu_datoA   = r_alu_a;
    assign o_alu_datoB   = r_alu_b;
    assign o_alu_op      = r_alu_op;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: ALU_LAT=1 instance with an ADD
// model, plus an ALU_LAT=3 instance driven by a hand-set ALU result.
module tb_alu_req_arbiter;

    localparam logic [5:0] OP_ADD = 6'b100000;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a0, b0, res0;
    logic [3:0] a3, b3, res3;
    logic [5:0] op0, op3;
    logic       busy0, busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_req_arbiter_if #(.N_REQ(2), .NB_DATA(4), .NB_OP(6)) bus0 ();
    alu_req_arbiter_if #(.N_REQ(2), .NB_DATA(4), .NB_OP(6)) bus3 ();

    alu_req_arbiter #(
        .NB_DATA(4), .NB_OP(6), .N_REQ(2), .ALU_LAT(1)
    ) dut0 (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .bus          (bus0),
        .o_alu_datoA  (a0),
        .o_alu_datoB  (b0),
        .o_alu_op     (op0),
        .i_alu_result (res0),
        .o_busy       (busy0)
    );

    alu_req_arbiter #(
        .NB_DATA(4), .NB_OP(6), .N_REQ(2), .ALU_LAT(3)
    ) dut3 (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .bus          (bus3),
        .o_alu_datoA  (a3),
        .o_alu_datoB  (b3),
        .o_alu_op     (op3),
        .i_alu_result (res3),
        .o_busy       (busy3)
    );

    // One-stage registered ALU supporting ADD only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res0 <= '0;
        else        res0 <= (op0 == OP_ADD) ? a0 + b0 : 4'd0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv0(input int k, input logic [3:0] a,
                        input logic [3:0] b, input logic [5:0] op);
        bus0.req_datoA[k*4 +: 4] = a;
        bus0.req_datoB[k*4 +: 4] = b;
        bus0.req_op[k*6 +: 6]    = op;
    endtask

    int exp_g;
    int last_g;
    int nrsp;
    int cyc;

    initial begin
        bus0.req_valid = '0;
        bus0.req_datoA = '0;
        bus0.req_datoB = '0;
        bus0.req_op    = '0;
        bus0.rsp_ready = '0;
        bus3.req_valid = '0;
        bus3.req_datoA = '0;
        bus3.req_datoB = '0;
        bus3.req_op    = '0;
        bus3.rsp_ready = '0;
        res3           = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_rspv",  32'(bus0.rsp_valid), 32'd0);
        chk("rst_rspd",  32'(bus0.rsp_data), 32'd0);
        chk("rst_alua",  32'(a0), 32'd0);
        chk("rst_aluop", 32'(op0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 0: 3 + 4.
        drv0(0, 4'd3, 4'd4, OP_ADD);
        drv0(1, 4'd5, 4'd6, OP_ADD);
        bus0.req_valid = 2'b01;
        #1 chk("t1_ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);
        chk("t1_alua", 32'(a0), 32'd3);
        chk("t1_alub", 32'(b0), 32'd4);
        chk("t1_aluop", 32'(op0), 32'(OP_ADD));
        chk("t1_busy", 32'(busy0), 32'd1);
        bus0.req_valid = 2'b10;
        #1 chk("t1_noready", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        chk("t1_rspv_early", 32'(bus0.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_rspv", 32'(bus0.rsp_valid), 32'd1);
        chk("t1_rspd", 32'(bus0.rsp_data), 32'd7);

        // Response held off for 5 cycles; other ready is ignored.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus0.rsp_ready = 2'b10;
            @(negedge clk);
            chk("t3_rspv", 32'(bus0.rsp_valid), 32'd1);
            chk("t3_rspd", 32'(bus0.rsp_data), 32'd7);
            chk("t3_ready", 32'(bus0.req_ready), 32'd0);
            chk("t3_busy", 32'(busy0), 32'd1);
        end
        bus0.rsp_ready = 2'b01;
        @(negedge clk);
        chk("t3_rspv_clr", 32'(bus0.rsp_valid), 32'd0);
        chk("t3_idle", 32'(busy0), 32'd0);

        // Both requesters continuously valid, responses always taken.
        drv0(0, 4'd1, 4'd2, OP_ADD);
        bus0.req_valid = 2'b11;
        bus0.rsp_ready = 2'b11;
        exp_g  = FIXED ? 0 : 1;
        last_g = 0;
        nrsp   = 0;
        cyc    = 0;
        #1;
        while (nrsp < 4 && cyc < 60) begin
            if (bus0.req_ready != 2'b00) begin
                chk("t2_grant", 32'(bus0.req_ready), 32'd1 << exp_g);
                last_g = exp_g;
                exp_g  = FIXED ? 0 : (exp_g ^ 1);
            end
            if (bus0.rsp_valid != 2'b00) begin
                chk("t2_rspv", 32'(bus0.rsp_valid), 32'd1 << last_g);
                chk("t2_rspd", 32'(bus0.rsp_data),
                    (last_g == 1) ? 32'd11 : 32'd3);
                nrsp++;
                if (nrsp == 4) bus0.req_valid = 2'b00;
            end
            if (nrsp < 4) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("t2_done", 32'(nrsp), 32'd4);
        @(negedge clk);
        chk("t2_idle", 32'(busy0), 32'd0);

        // Reset while waiting on the ALU.
        bus0.req_valid = 2'b11;
        #1 chk("t4_ready", 32'(bus0.req_ready), FIXED ? 32'd1 : 32'd2);
        @(negedge clk);
        chk("t4_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(busy0), 32'd0);
        chk("t4_rst_alua", 32'(a0), 32'd0);
        chk("t4_rst_alub", 32'(b0), 32'd0);
        chk("t4_rst_aluop", 32'(op0), 32'd0);
        chk("t4_rst_rspv", 32'(bus0.rsp_valid), 32'd0);
        chk("t4_rst_rspd", 32'(bus0.rsp_data), 32'd0);
        chk("t4_rst_ready", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("t4_ptr0", 32'(bus0.req_ready), 32'd1);
        bus0.req_valid = 2'b10;
        #1 chk("t4_req1", 32'(bus0.req_ready), 32'd2);
        bus0.req_valid = 2'b00;

        // Three-cycle ALU: only the value present at T+4 is captured.
        @(negedge clk);
        bus3.req_datoA[3:0] = 4'd2;
        bus3.req_datoB[3:0] = 4'd3;
        bus3.req_op[5:0]    = OP_ADD;
        bus3.req_valid      = 2'b01;
        res3                = 4'd1;
        #1 chk("t6_ready", 32'(bus3.req_ready), 32'd1);
        @(negedge clk);
        bus3.req_valid = 2'b00;
        chk("t6_alua", 32'(a3), 32'd2);
        res3 = 4'd5;
        @(negedge clk);
        chk("t6_rspv_t1", 32'(bus3.rsp_valid), 32'd0);
        res3 = 4'd6;
        @(negedge clk);
        chk("t6_rspv_t2", 32'(bus3.rsp_valid), 32'd0);
        res3 = 4'd9;
        @(negedge clk);
        chk("t6_rspv_t3", 32'(bus3.rsp_valid), 32'd0);
        res3 = 4'hB;
        @(negedge clk);
        chk("t6_rspv_t4", 32'(bus3.rsp_valid), 32'd1);
        chk("t6_rspd", 32'(bus3.rsp_data), 32'hB);
        res3 = 4'd0;
        @(negedge clk);
        chk("t6_rspd_hold", 32'(bus3.rsp_data), 32'hB);
        bus3.rsp_ready = 2'b01;
        @(negedge clk);
        chk("t6_rspv_clr", 32'(bus3.rsp_valid), 32'd0);
        chk("t6_idle", 32'(busy3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
